// File: rtl/cmult_share_arb.sv
// cmult_share_arb: round-robin arbiter/sequencer sharing one pipelined complex multiplier between two requesters
//   CLK, s_RST         clock and synchronous active-low reset
//   prio_fixed         1 = requester 0 wins conflicts, 0 = round-robin
//   rN_valid/rN_ready  operand handshake per requester (ready is combinational)
//   rN_a_*, rN_b_*     signed operands; rN_conj selects multiply by conj(b)
//   m_a_*, m_b_*       registered operands to the multiplier, m_strobe marks them valid
//   m_p_*, m_out_strobe  multiplier products and their valid
//   rN_p_*, rN_out_strobe  registered result and one-cycle valid per requester
//   route_err          sticky flag: multiplier result valid disagreed with the tag pipeline
module cmult_share_arb #(
    parameter int I_Q_Width    = 16,
    parameter int MULT_LATENCY = 1
) (
    input  logic                   CLK,
    input  logic                   s_RST,
    input  logic                   prio_fixed,
    input  logic                   r0_valid,
    output logic                   r0_ready,
    input  logic [I_Q_Width-1:0]   r0_a_i,
    input  logic [I_Q_Width-1:0]   r0_a_q,
    input  logic [I_Q_Width-1:0]   r0_b_i,
    input  logic [I_Q_Width-1:0]   r0_b_q,
    input  logic                   r0_conj,
    input  logic                   r1_valid,
    output logic                   r1_ready,
    input  logic [I_Q_Width-1:0]   r1_a_i,
    input  logic [I_Q_Width-1:0]   r1_a_q,
    input  logic [I_Q_Width-1:0]   r1_b_i,
    input  logic [I_Q_Width-1:0]   r1_b_q,
    input  logic                   r1_conj,
    output logic [I_Q_Width-1:0]   m_a_i,
    output logic [I_Q_Width-1:0]   m_a_q,
    output logic [I_Q_Width-1:0]   m_b_i,
    output logic [I_Q_Width-1:0]   m_b_q,
    output logic                   m_strobe,
    input  logic [2*I_Q_Width-1:0] m_p_i,
    input  logic [2*I_Q_Width-1:0] m_p_q,
    input  logic                   m_out_strobe,
    output logic [2*I_Q_Width-1:0] r0_p_i,
    output logic [2*I_Q_Width-1:0] r0_p_q,
    output logic                   r0_out_strobe,
    output logic [2*I_Q_Width-1:0] r1_p_i,
    output logic [2*I_Q_Width-1:0] r1_p_q,
    output logic                   r1_out_strobe,
    output logic                   route_err
);
    localparam logic [I_Q_Width-1:0] q_min = {1'b1, {(I_Q_Width-1){1'b0}}};
    localparam logic [I_Q_Width-1:0] q_max = {1'b0, {(I_Q_Width-1){1'b1}}};

    logic                    last;
    logic                    xfer;
    logic                    m_id;
    logic [I_Q_Width-1:0]    sel_a_i, sel_a_q, sel_b_i, sel_b_q, nxt_b_q;
    logic                    sel_conj;
    logic [MULT_LATENCY-1:0] tag_v, tag_id;
    logic                    exit_v, exit_id;

    // last == 1 means requester 0 owns the next round-robin conflict
    always_comb begin
        r0_ready = s_RST & r0_valid & ~(r1_valid & ~prio_fixed & ~last);
        r1_ready = s_RST & r1_valid & (~r0_valid | (~prio_fixed & ~last));
        xfer     = r0_ready | r1_ready;
        sel_a_i  = r1_ready ? r1_a_i : r0_a_i;
        sel_a_q  = r1_ready ? r1_a_q : r0_a_q;
        sel_b_i  = r1_ready ? r1_b_i : r0_b_i;
        sel_b_q  = r1_ready ? r1_b_q : r0_b_q;
        sel_conj = r1_ready ? r1_conj : r0_conj;
        // negating the most negative value would wrap, so clamp it to the maximum
        nxt_b_q  = !sel_conj ? sel_b_q : (sel_b_q == q_min) ? q_max : -sel_b_q;
        exit_v   = tag_v[MULT_LATENCY-1];
        exit_id  = tag_id[MULT_LATENCY-1];
    end

    always_ff @(posedge CLK) begin
        if (!s_RST) begin
            last     <= 1'b1;
            m_strobe <= 1'b0;
            m_id     <= 1'b0;
            m_a_i    <= '0;
            m_a_q    <= '0;
            m_b_i    <= '0;
            m_b_q    <= '0;
        end else begin
            m_strobe <= xfer;
            if (xfer) begin
                last  <= r1_ready;
                m_id  <= r1_ready;
                m_a_i <= sel_a_i;
                m_a_q <= sel_a_q;
                m_b_i <= sel_b_i;
                m_b_q <= nxt_b_q;
            end
        end
    end

    // tag pipeline mirrors the multiplier latency so the id exits with m_out_strobe
    always_ff @(posedge CLK) begin
        if (!s_RST) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v[0]  <= m_strobe;
            tag_id[0] <= m_id;
            for (int k = 1; k < MULT_LATENCY; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!s_RST) begin
            r0_out_strobe <= 1'b0;
            r1_out_strobe <= 1'b0;
            r0_p_i        <= '0;
            r0_p_q        <= '0;
            r1_p_i        <= '0;
            r1_p_q        <= '0;
            route_err     <= 1'b0;
        end else begin
            r0_out_strobe <= m_out_strobe & exit_v & ~exit_id;
            r1_out_strobe <= m_out_strobe & exit_v & exit_id;
            if (m_out_strobe != exit_v)
                route_err <= 1'b1;
            if (m_out_strobe & exit_v & ~exit_id) begin
                r0_p_i <= m_p_i;
                r0_p_q <= m_p_q;
            end
            if (m_out_strobe & exit_v & exit_id) begin
                r1_p_i <= m_p_i;
                r1_p_q <= m_p_q;
            end
        end
    end
endmodule

// File: tb/tb_cmult_share_arb.sv
// tb_cmult_share_arb: directed bench for cmult_share_arb with a one-cycle complex multiplier model
module tb_cmult_share_arb;
    logic CLK = 1'b0;
    logic s_RST, prio_fixed, inj;
    logic r0_valid, r0_ready, r0_conj, r1_valid, r1_ready, r1_conj;
    logic signed [15:0] r0_a_i, r0_a_q, r0_b_i, r0_b_q;
    logic signed [15:0] r1_a_i, r1_a_q, r1_b_i, r1_b_q;
    logic signed [15:0] m_a_i, m_a_q, m_b_i, m_b_q;
    logic m_strobe, m_out_strobe;
    logic signed [31:0] m_p_i, m_p_q, r0_p_i, r0_p_q, r1_p_i, r1_p_q;
    logic r0_out_strobe, r1_out_strobe, route_err;
    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    cmult_share_arb dut (
        .CLK(CLK), .s_RST(s_RST), .prio_fixed(prio_fixed),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a_i(r0_a_i), .r0_a_q(r0_a_q),
        .r0_b_i(r0_b_i), .r0_b_q(r0_b_q), .r0_conj(r0_conj),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a_i(r1_a_i), .r1_a_q(r1_a_q),
        .r1_b_i(r1_b_i), .r1_b_q(r1_b_q), .r1_conj(r1_conj),
        .m_a_i(m_a_i), .m_a_q(m_a_q), .m_b_i(m_b_i), .m_b_q(m_b_q), .m_strobe(m_strobe),
        .m_p_i(m_p_i), .m_p_q(m_p_q), .m_out_strobe(m_out_strobe),
        .r0_p_i(r0_p_i), .r0_p_q(r0_p_q), .r0_out_strobe(r0_out_strobe),
        .r1_p_i(r1_p_i), .r1_p_q(r1_p_q), .r1_out_strobe(r1_out_strobe),
        .route_err(route_err)
    );

    function automatic logic signed [31:0] mac(input logic signed [31:0] x, y, u, v, input logic sub);
        return sub ? x * y - u * v : x * y + u * v;
    endfunction

    // one-cycle multiplier, reset together with the arbiter; inj forces a stray result valid
    always_ff @(posedge CLK) begin
        if (!s_RST) begin
            m_out_strobe <= 1'b0;
            m_p_i        <= '0;
            m_p_q        <= '0;
        end else begin
            m_out_strobe <= m_strobe | inj;
            m_p_i        <= mac(m_a_i, m_b_i, m_a_q, m_b_q, 1'b1);
            m_p_q        <= mac(m_a_i, m_b_q, m_a_q, m_b_i, 1'b0);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic set_r0(input logic signed [15:0] ai, aq, bi, bq, input logic cj);
        r0_a_i = ai; r0_a_q = aq; r0_b_i = bi; r0_b_q = bq; r0_conj = cj;
    endtask

    task automatic set_r1(input logic signed [15:0] ai, aq, bi, bq, input logic cj);
        r1_a_i = ai; r1_a_q = aq; r1_b_i = bi; r1_b_q = bq; r1_conj = cj;
    endtask

    task automatic test_reset();
        s_RST = 1'b0; prio_fixed = 1'b0; inj = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0;
        set_r0(0, 0, 0, 0, 0);
        set_r1(0, 0, 0, 0, 0);
        tick();
        tick();
        r0_valid = 1'b1; r1_valid = 1'b1;
        #1;
        checks++; if ({r0_ready, r1_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready got=%b exp=00", {r0_ready, r1_ready}); end
        checks++; if ({m_strobe, route_err, r0_out_strobe, r1_out_strobe} !== 4'b0) begin errors++; $display("FAIL rst_flags got=%b exp=0000", {m_strobe, route_err, r0_out_strobe, r1_out_strobe}); end
        checks++; if ({m_a_i, m_b_q, r0_p_i, r1_p_q} !== 96'd0) begin errors++; $display("FAIL rst_data got=%h exp=0", {m_a_i, m_b_q, r0_p_i, r1_p_q}); end
        s_RST = 1'b1;
        #1;
        checks++; if ({r0_ready, r1_ready} !== 2'b10) begin errors++; $display("FAIL rst_first_conflict got=%b exp=10", {r0_ready, r1_ready}); end
        r0_valid = 1'b0; r1_valid = 1'b0;
        tick();
    endtask

    task automatic test_single();
        set_r0(3, 4, 1, 2, 0);
        r0_valid = 1'b1;
        #1;
        checks++; if ({r0_ready, r1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready got=%b exp=10", {r0_ready, r1_ready}); end
        tick();
        r0_valid = 1'b0;
        checks++; if ({m_strobe, m_a_i, m_a_q, m_b_i, m_b_q} !== {1'b1, 16'sd3, 16'sd4, 16'sd1, 16'sd2}) begin errors++; $display("FAIL single_operands got=%h", {m_strobe, m_a_i, m_a_q, m_b_i, m_b_q}); end
        tick();
        checks++; if ({m_strobe, r0_out_strobe} !== 2'b00) begin errors++; $display("FAIL single_early got=%b exp=00", {m_strobe, r0_out_strobe}); end
        tick();
        checks++; if ({r0_out_strobe, r1_out_strobe} !== 2'b10) begin errors++; $display("FAIL single_strobe got=%b exp=10", {r0_out_strobe, r1_out_strobe}); end
        checks++; if (r0_p_i !== -32'sd5 || r0_p_q !== 32'sd10) begin errors++; $display("FAIL single_product got=(%0d,%0d) exp=(-5,10)", r0_p_i, r0_p_q); end
        tick();
        checks++; if (r0_out_strobe !== 1'b0 || r0_p_i !== -32'sd5) begin errors++; $display("FAIL single_hold got=%b,%0d exp=0,-5", r0_out_strobe, r0_p_i); end
    endtask

    task automatic test_conj_sat();
        set_r1(1, 1, 0, -16'sd32768, 1);
        r1_valid = 1'b1;
        #1;
        checks++; if ({r0_ready, r1_ready} !== 2'b01) begin errors++; $display("FAIL conj_ready got=%b exp=01", {r0_ready, r1_ready}); end
        tick();
        r1_valid = 1'b0;
        checks++; if (m_b_q !== 16'sd32767 || m_b_i !== 16'sd0) begin errors++; $display("FAIL conj_sat got=(%0d,%0d) exp=(0,32767)", m_b_i, m_b_q); end
        tick();
        tick();
        checks++; if ({r0_out_strobe, r1_out_strobe} !== 2'b01) begin errors++; $display("FAIL conj_strobe got=%b exp=01", {r0_out_strobe, r1_out_strobe}); end
        checks++; if (r1_p_i !== -32'sd32767 || r1_p_q !== 32'sd32767) begin errors++; $display("FAIL conj_product got=(%0d,%0d) exp=(-32767,32767)", r1_p_i, r1_p_q); end
        checks++; if (r0_p_i !== -32'sd5) begin errors++; $display("FAIL conj_other_hold got=%0d exp=-5", r0_p_i); end
        tick();
    endtask

    task automatic test_round_robin();
        prio_fixed = 1'b0;
        set_r0(2, 0, 3, 0, 0);
        set_r1(0, 1, 5, 0, 0);
        r0_valid = 1'b1; r1_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (i < 6) begin
                checks++; if ({r0_ready, r1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_grant%0d got=%b", i, {r0_ready, r1_ready}); end
            end
            tick();
            if (i == 5) begin r0_valid = 1'b0; r1_valid = 1'b0; end
            if (i >= 2 && i <= 7) begin
                checks++; if ({r0_out_strobe, r1_out_strobe} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_result%0d got=%b", i, {r0_out_strobe, r1_out_strobe}); end
                if (i % 2 == 0) begin
                    checks++; if (r0_p_i !== 32'sd6 || r0_p_q !== 32'sd0) begin errors++; $display("FAIL rr_r0_product got=(%0d,%0d) exp=(6,0)", r0_p_i, r0_p_q); end
                end else begin
                    checks++; if (r1_p_i !== 32'sd0 || r1_p_q !== 32'sd5) begin errors++; $display("FAIL rr_r1_product got=(%0d,%0d) exp=(0,5)", r1_p_i, r1_p_q); end
                end
            end else begin
                checks++; if ({r0_out_strobe, r1_out_strobe} !== 2'b00) begin errors++; $display("FAIL rr_idle%0d got=%b exp=00", i, {r0_out_strobe, r1_out_strobe}); end
            end
        end
    endtask

    task automatic test_fixed_priority();
        int n0, n1;
        n0 = 0; n1 = 0;
        prio_fixed = 1'b1;
        r0_valid = 1'b1; r1_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (i < 4) begin
                checks++; if ({r0_ready, r1_ready} !== 2'b10) begin errors++; $display("FAIL fixed_grant%0d got=%b exp=10", i, {r0_ready, r1_ready}); end
            end
            tick();
            if (i == 3) begin r0_valid = 1'b0; r1_valid = 1'b0; end
            n0 += int'(r0_out_strobe);
            n1 += int'(r1_out_strobe);
        end
        checks++; if (n0 != 4 || n1 != 0) begin errors++; $display("FAIL fixed_results got=%0d/%0d exp=4/0", n0, n1); end
        prio_fixed = 1'b0;
    endtask

    task automatic test_reset_midflight();
        set_r0(3, 4, 1, 2, 0);
        r0_valid = 1'b1;
        tick();
        r0_valid = 1'b0;
        set_r1(3, 4, 1, 2, 1);
        r1_valid = 1'b1;
        tick();
        r1_valid = 1'b0;
        s_RST = 1'b0;
        tick();
        checks++; if ({r0_out_strobe, r1_out_strobe, m_strobe, route_err} !== 4'b0) begin errors++; $display("FAIL mid_flags got=%b exp=0000", {r0_out_strobe, r1_out_strobe, m_strobe, route_err}); end
        checks++; if ({m_a_i, m_a_q, m_b_i, m_b_q} !== 64'd0) begin errors++; $display("FAIL mid_operands got=%h exp=0", {m_a_i, m_a_q, m_b_i, m_b_q}); end
        checks++; if ({r0_p_i, r0_p_q, r1_p_i, r1_p_q} !== 128'd0) begin errors++; $display("FAIL mid_results got=%h exp=0", {r0_p_i, r0_p_q, r1_p_i, r1_p_q}); end
        s_RST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if ({r0_out_strobe, r1_out_strobe, route_err} !== 3'b0) begin errors++; $display("FAIL mid_quiet%0d got=%b exp=000", i, {r0_out_strobe, r1_out_strobe, route_err}); end
        end
        r1_valid = 1'b1;
        tick();
        r1_valid = 1'b0;
        tick();
        checks++; if (r1_out_strobe !== 1'b0) begin errors++; $display("FAIL mid_new_early got=%b exp=0", r1_out_strobe); end
        tick();
        checks++; if (r1_out_strobe !== 1'b1 || r1_p_i !== 32'sd11 || r1_p_q !== -32'sd2) begin errors++; $display("FAIL mid_new got=%b,(%0d,%0d) exp=1,(11,-2)", r1_out_strobe, r1_p_i, r1_p_q); end
        tick();
    endtask

    task automatic test_protocol_error();
        inj = 1'b1;
        tick();
        inj = 1'b0;
        checks++; if (route_err !== 1'b0) begin errors++; $display("FAIL proto_early got=%b exp=0", route_err); end
        tick();
        checks++; if ({route_err, r0_out_strobe, r1_out_strobe} !== 3'b100) begin errors++; $display("FAIL proto_set got=%b exp=100", {route_err, r0_out_strobe, r1_out_strobe}); end
        tick();
        tick();
        checks++; if (route_err !== 1'b1) begin errors++; $display("FAIL proto_sticky got=%b exp=1", route_err); end
        s_RST = 1'b0;
        tick();
        s_RST = 1'b1;
        checks++; if (route_err !== 1'b0) begin errors++; $display("FAIL proto_clear got=%b exp=0", route_err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_conj_sat();
        test_round_robin();
        test_fixed_priority();
        test_reset_midflight();
        test_protocol_error();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cmult_share_arb.md
# cmult_share_arb

Round-robin arbiter and sequencer that time-shares one pipelined complex multiplier between two requesters in the synchronization path, for example short-preamble autocorrelation and CFO de-rotation. Each cycle it accepts at most one operand set through a valid/ready handshake. It optionally conjugates operand b, drives the shared multiplier with registered operands and a strobe, and tracks every in-flight product with a tag pipeline. Each result is returned to its originating requester with a one-cycle strobe.

## Interface
- I_Q_Width, 16, width of each I/Q operand; products are 2*I_Q_Width bits.
- MULT_LATENCY, 1, cycles from m_strobe high to m_out_strobe high on the attached multiplier; legal range 1..8.
- CLK  input  1  clock; all logic is on the rising edge.
- s_RST  input  1  reset, synchronous and active-low.
- prio_fixed  input  1  1 = requester 0 always wins a conflict; 0 = round-robin.
- rN_valid  input  1  requester N (N=0,1) presents operands.
- rN_ready  output  1  requester N is granted this cycle; combinational from valids, prio_fixed and the RR pointer.
- rN_a_i, rN_a_q, rN_b_i, rN_b_q  input  I_Q_Width each  signed operands.
- rN_conj  input  1  1 = multiply by conj(b).
- m_a_i, m_a_q, m_b_i, m_b_q  output  I_Q_Width each  registered operands to the multiplier.
- m_strobe  output  1  operand-valid strobe to the multiplier.
- m_p_i, m_p_q  input  2*I_Q_Width each  multiplier products.
- m_out_strobe  input  1  multiplier result valid.
- rN_p_i, rN_p_q  output  2*I_Q_Width each  registered result for requester N.
- rN_out_strobe  output  1  one-cycle result-valid pulse for requester N.
- route_err  output  1  sticky error flag: result/tag mismatch detected.

## Operation
- Grant rules:
  - Only r0_valid is high: grant 0. Only r1_valid is high: grant 1.
  - Both high and prio_fixed=1: grant 0.
  - Both high and prio_fixed=0: grant the requester not granted last (RR pointer `last`).
  - The transfer occurs on the edge where rN_valid and rN_ready are both high.
- RR pointer `last` updates to the granted index on every transfer, whatever prio_fixed is. Reset value: 1, so requester 0 wins the first conflict.
- Conjugation: with rN_conj=1, m_b_q is -rN_b_q, saturated. An input of -2^(I_Q_Width-1) maps to 2^(I_Q_Width-1)-1. m_b_i is passed unchanged.
- Operand stage: the transfer edge loads m_* and sets m_strobe=1 for exactly one cycle. With no transfer, m_strobe=0 and m_* hold their values.
- Tag pipeline: MULT_LATENCY stages of {valid, id}. It is loaded with {m_strobe, granted id} and shifts every cycle, so a tag exits aligned with m_out_strobe.
- Result stage, on m_out_strobe=1 with a valid exiting tag:
  - Register m_p_i/m_p_q into r<id>_p_i/p_q.
  - Pulse r<id>_out_strobe for one cycle. The other requester's strobe stays 0 and its outputs hold.
- route_err is set and stays set until reset if m_out_strobe and the tag valid differ in any cycle. In that case the result is dropped.
- Width rule: products pass through unchanged, with no rounding or truncation.

## Timing
- The arbiter sustains one accept per cycle; there is no bubble between back-to-back grants.
- Accept at edge t: m_strobe is high in cycle t+1, m_out_strobe at t+1+MULT_LATENCY, rN_out_strobe at t+2+MULT_LATENCY. With the default parameter that is 3 cycles after the accept edge.
- Results return in acceptance order.
- Reset (s_RST=0 at an edge) has the following effects:
  - rN_out_strobe, m_strobe, route_err, and all tag valids go to 0; `last` goes to 1.
  - m_*, rN_p_i and rN_p_q go to 0.
  - rN_ready is forced to 0 while s_RST=0.
  - In-flight products are discarded. Any m_out_strobe in the first MULT_LATENCY cycles after reset sets route_err unless the multiplier itself is also reset.
- A requester that lowers valid without being granted loses nothing; there is no request latching.

## Test plan
- Single request: r0 sends a=(3,4), b=(1,2), conj=0, for one cycle. Required: r0_out_strobe 3 cycles later with p=(-5,10); r1_out_strobe stays 0.
- Conjugate and saturation: r1 sends a=(1,1), b=(0,-32768), conj=1. Required: m_b_q=32767 and r1 p=(-32767,32767).
- Round-robin: both valid continuously for 6 cycles with prio_fixed=0. Required: grants 0,1,0,1,0,1 and results alternate r0/r1 on consecutive cycles.
- Fixed priority: both valid for 4 cycles with prio_fixed=1. Required: r0 granted every cycle, r1_ready=0, no r1 result.
- Reset mid-flight: accept two requests, then assert s_RST=0 for one cycle before either result returns, with the multiplier also reset. Required: no rN_out_strobe, all outputs 0, route_err=0; a new request after release completes in 3 cycles.
- Protocol error: inject m_out_strobe with no request outstanding. Required: route_err rises the next cycle and stays high; no rN_out_strobe.
